// File: rtl/nmux_rr_feeder_pkg.sv
// Shared sizes, FSM encoding and index helper for the NMux round-robin feeder.
package nmux_rr_feeder_pkg;

  localparam int unsigned N     = 5;
  localparam int unsigned W     = 8;
  localparam int unsigned SEL_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Channel index following i, wrapping N-1 back to 0.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (i == SEL_W'(N - 1)) ? '0 : i + SEL_W'(1);
  endfunction

endpackage

// File: rtl/nmux_rr_feeder_if.sv
// Source-side and NMux-side signal bundle of the round-robin feeder.
interface nmux_rr_feeder_if;
  import nmux_rr_feeder_pkg::*;

  logic [N-1:0]     io_in_valid;
  logic [N-1:0]     io_in_ready;
  logic [N*W-1:0]   io_in_data;
  logic [N*W-1:0]   io_Dvect;
  logic [SEL_W-1:0] io_sel;
  logic             io_out_valid;
  logic             io_out_ready;

  modport slave (
    input  io_in_valid, io_in_data, io_out_ready,
    output io_in_ready, io_Dvect, io_sel, io_out_valid
  );

  modport master (
    output io_in_valid, io_in_data, io_out_ready,
    input  io_in_ready, io_Dvect, io_sel, io_out_valid
  );

endinterface

// File: rtl/nmux_rr_feeder_pick.sv
// Rotating-priority encoder: first set bit of mask searching from ptr upward with wrap.
module nmux_rr_feeder_pick
  import nmux_rr_feeder_pkg::*;
(
  input  logic [N-1:0]     mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    logic [SEL_W:0] j;
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (j >= (SEL_W + 1)'(N)) begin
        j = j - (SEL_W + 1)'(N);
      end
      if (!found && mask[j[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = j[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/nmux_rr_feeder.sv
// One-byte buffer per source channel with round-robin grant onto the NMux select.
module nmux_rr_feeder
  import nmux_rr_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  nmux_rr_feeder_if.slave   bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     full_vec;
  logic [N-1:0]     nxt_mask;
  logic             hs;
  logic             out_valid;
  logic             idle_found, nxt_found;
  logic [SEL_W-1:0] idle_idx, nxt_idx, sel_succ;

  assign hs       = (state_q == GRANT) && bus.io_out_ready;
  assign sel_succ = next_idx(sel_q);
  assign nxt_mask = full_vec & ~(N'(1) << sel_q);

  for (genvar k = 0; k < N; k++) begin : g_slot
    logic          full_q, full_d;
    logic [W-1:0]  data_q, data_d;
    logic          accept, drain;

    // Granted slot is always full, so accept and drain never coincide.
    assign accept = bus.io_in_valid[k] && !full_q;
    assign drain  = hs && (sel_q == SEL_W'(k));

    always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (accept) begin
        full_d = 1'b1;
        data_d = bus.io_in_data[k*W +: W];
      end else if (drain) begin
        full_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else begin
        full_q <= full_d;
        data_q <= data_d;
      end
    end

    assign full_vec[k]              = full_q;
    assign bus.io_in_ready[k]       = ~full_q;
    assign bus.io_Dvect[k*W +: W]   = data_q;
  end

  nmux_rr_feeder_pick u_pick_idle (
    .mask  (full_vec),
    .ptr   (ptr_q),
    .found (idle_found),
    .idx   (idle_idx)
  );

  nmux_rr_feeder_pick u_pick_next (
    .mask  (nxt_mask),
    .ptr   (sel_succ),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Back-to-back grants use only buffers that were full before this edge.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (idle_found) begin
          sel_d   = idle_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.io_out_ready) begin
          ptr_d = sel_succ;
          if (nxt_found) begin
            sel_d = nxt_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    if (state_q == GRANT) begin
      out_valid = 1'b1;
    end
  end

  assign bus.io_out_valid = out_valid;
  assign bus.io_sel       = sel_q;

endmodule
